// File: rtl/b_block_remap_engine_if.sv
// SRAM-side bus of the B-operand block remap engine: source read port and
// destination write port. The engine is the master; the memories are the slave.
interface b_block_remap_engine_if #(
   parameter int DataWidth = 8,
   parameter int AddrWidth = 12
);
   logic [AddrWidth-1:0] src_addr_o;
   logic [DataWidth-1:0] src_rdata_i;
   logic [AddrWidth-1:0] dst_addr_o;
   logic [DataWidth-1:0] dst_wdata_o;
   logic                 dst_we_o;

   modport master (
      output src_addr_o,
      input  src_rdata_i,
      output dst_addr_o,
      output dst_wdata_o,
      output dst_we_o
   );

   modport slave (
      input  src_addr_o,
      output src_rdata_i,
      input  dst_addr_o,
      input  dst_wdata_o,
      input  dst_we_o
   );
endinterface

// File: rtl/b_block_remap_engine.sv
// Copies a row-major K x N int8 matrix into 4x4-block order for the GeMM B path.
// Define REMAP_INTRA_COL_MAJOR_EN to store each 4x4 tile column-major (transposed).
module b_block_remap_engine #(
   parameter int DataWidth     = 8,
   parameter int DataDepth     = 4096,
   parameter int AddrWidth     = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
   parameter int SizeAddrWidth = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [SizeAddrWidth-1:0] K_i,
   input  logic [SizeAddrWidth-1:0] N_i,
   b_block_remap_engine_if.master   bus,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   localparam logic [SizeAddrWidth-1:0] SOne   = SizeAddrWidth'(1);
   localparam logic [31:0]              DepthW = 32'(DataDepth);

   state_e state_q, state_d;
   logic [SizeAddrWidth-1:0] k_q, k_d, n_q, n_d, kb_q, kb_d, nb_q, nb_d;
   logic [1:0]               fast_q, fast_d, slow_q, slow_d;
   logic                     first_q, first_d, err_q, err_d;
   logic [AddrWidth-1:0]     dst_addr_q, dst_addr_d;

   logic [31:0]          prod;
   logic                 legal, last_elem;
   logic                 fast_wrap, slow_wrap, nb_wrap, kb_wrap;
   logic [1:0]           r, c;
   logic [AddrWidth-1:0] kb_a, nb_a, n_a, r_a, c_a, blk_a, src_addr_c, dst_addr_c;

   assign prod  = 32'(K_i) * 32'(N_i);
   assign legal = (K_i != '0) && (N_i != '0) && (K_i[1:0] == 2'b00) &&
                  (N_i[1:0] == 2'b00) && (prod <= DepthW);

   // The inner counter walks columns (row-major tile) or rows (column-major tile);
   // either way the destination offset is slow*4+fast, so writes stay sequential.
`ifdef REMAP_INTRA_COL_MAJOR_EN
   assign r = fast_q;
   assign c = slow_q;
`else
   assign r = slow_q;
   assign c = fast_q;
`endif

   assign fast_wrap = (fast_q == 2'd3);
   assign slow_wrap = (slow_q == 2'd3);
   assign nb_wrap   = (nb_q == (n_q >> 2) - SOne);
   assign kb_wrap   = (kb_q == (k_q >> 2) - SOne);
   assign last_elem = fast_wrap && slow_wrap && nb_wrap && kb_wrap;

   assign kb_a  = AddrWidth'(kb_q);
   assign nb_a  = AddrWidth'(nb_q);
   assign n_a   = AddrWidth'(n_q);
   assign r_a   = AddrWidth'(r);
   assign c_a   = AddrWidth'(c);
   assign blk_a = kb_a * (n_a >> 2) + nb_a;

   assign src_addr_c = ((kb_a << 2) + r_a) * n_a + (nb_a << 2) + c_a;
   assign dst_addr_c = (blk_a << 4) + (AddrWidth'(slow_q) << 2) + AddrWidth'(fast_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i && legal) state_d = RUN;
         RUN:     if (last_elem) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o          = (state_q == RUN) || (state_q == DRAIN);
      done_o          = (state_q == DONE);
      err_o           = err_q;
      bus.dst_we_o    = ((state_q == RUN) && !first_q) || (state_q == DRAIN);
      bus.src_addr_o  = (state_q == RUN) ? src_addr_c : '0;
      bus.dst_addr_o  = dst_addr_q;
      bus.dst_wdata_o = bus.src_rdata_i;
   end

   always_comb begin
      k_d        = k_q;
      n_d        = n_q;
      kb_d       = kb_q;
      nb_d       = nb_q;
      fast_d     = fast_q;
      slow_d     = slow_q;
      first_d    = first_q;
      dst_addr_d = dst_addr_q;
      err_d      = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            if (legal) begin
               k_d     = K_i;
               n_d     = N_i;
               kb_d    = '0;
               nb_d    = '0;
               fast_d  = '0;
               slow_d  = '0;
               first_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         RUN: begin
            first_d    = 1'b0;
            dst_addr_d = dst_addr_c;
            fast_d     = fast_q + 2'd1;
            if (fast_wrap) begin
               slow_d = slow_q + 2'd1;
               if (slow_wrap) begin
                  if (nb_wrap) begin
                     nb_d = '0;
                     kb_d = kb_wrap ? '0 : kb_q + SOne;
                  end else begin
                     nb_d = nb_q + SOne;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q        <= '0;
         n_q        <= '0;
         kb_q       <= '0;
         nb_q       <= '0;
         fast_q     <= '0;
         slow_q     <= '0;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
         dst_addr_q <= '0;
      end else begin
         k_q        <= k_d;
         n_q        <= n_d;
         kb_q       <= kb_d;
         nb_q       <= nb_d;
         fast_q     <= fast_d;
         slow_q     <= slow_d;
         first_q    <= first_d;
         err_q      <= err_d;
         dst_addr_q <= dst_addr_d;
      end
   end
endmodule

// File: doc/b_block_remap_engine.md
Name: b_block_remap_engine

Overview:
- Hardware DMA stage that sits directly upstream of the GeMM core's B-operand path.
- Reads a row-major K x N int8 matrix from a single-port source SRAM and writes it, reordered into 4x4 blocks, to a destination SRAM.
- The core then streams the destination SRAM 16 elements per block.
- Replaces the software remap done in benches today; sizes are runtime inputs.

Parameters:
- DataWidth, 8, element width in bits.
- DataDepth, 4096, words per SRAM.
- AddrWidth, $clog2(DataDepth) (1 if DataDepth<=1), SRAM address width.
- SizeAddrWidth, 8, width of the K/N size inputs.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  launch request, sampled on a rising edge.
- K_i  in  SizeAddrWidth  rows of B.
- N_i  in  SizeAddrWidth  columns of B.
- src_addr_o  out  AddrWidth  source SRAM read address.
- src_rdata_i  in  DataWidth  source read data, valid the cycle after the address.
- dst_addr_o  out  AddrWidth  destination write address.
- dst_wdata_o  out  DataWidth  destination write data.
- dst_we_o  out  1  destination write enable.
- busy_o  out  1  high while in RUN or DRAIN.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle size-error pulse.

Behaviour:
- Reset (async, immediate): all outputs 0, FSM=IDLE, counters 0. Any in-flight transfer is abandoned and no further writes occur.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 with legal sizes: latch K,N and go to RUN.
  - start_i=1 with illegal sizes: err_o=1 for one cycle, stay IDLE.
  - Legal sizes: K>0, N>0, K%4==0, N%4==0, K*N<=DataDepth.
- Counters in RUN: kb (block row), nb (block col), r (row in block), c (col in block).
  - Increment order: c fastest, then r, then nb, then kb.
  - Element index j runs 0..K*N-1, one per cycle.
- RUN, cycle j:
  - src_addr_o = (kb*4+r)*N + nb*4 + c.
  - Destination address for that element = (kb*(N/4)+nb)*16 + r*4 + c; it is registered one cycle so it aligns with the read data.
  - Arithmetic is AddrWidth-wide, unsigned; legality check guarantees no overflow.
- Writes:
  - dst_we_o=1 in RUN cycles 1..K*N-1 and in the single DRAIN cycle, i.e. exactly K*N writes.
  - dst_wdata_o = src_rdata_i, combinational pass-through.
- After the last element: RUN -> DRAIN (final write) -> DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge t0 -> first write in cycle t0+2 -> done_o in cycle t0+K*N+2.
- start_i while busy_o=1: ignored; latched sizes unaffected.
- start_i in the DONE cycle: ignored.
- K_i/N_i changes mid-transfer: no effect.
- src_addr_o is 0 outside RUN; dst_addr_o and dst_wdata_o are don't-care when dst_we_o=0.
- busy_o=1 in RUN and DRAIN only.

Optional Feature:
- Macro: REMAP_INTRA_COL_MAJOR_EN.
- Defined:
  - Within each block r increments fastest, then c.
  - Destination intra-block offset is c*4+r, so blocks are stored column-major (transposed 4x4 tiles).
  - Block order and cycle count are unchanged.
- Undefined: row-major intra-block order as specified above.

Test Plan:
- Basic remap: source mem[i]=i, K=12, N=8, start pulse.
  - dst[0..15] = 0,1,2,3,8,9,10,11,16,17,18,19,24,25,26,27.
  - dst[16..19] = 4,5,6,7.
  - dst[32] = 32.
  - Exactly 96 dst_we_o cycles; done_o in cycle t0+98.
- Illegal sizes: K=6, N=8 -> err_o pulse the next cycle, no dst_we_o, busy_o stays 0. Repeat with K=0, and with K=128, N=64 (K*N > DataDepth).
- Start while busy: start_i re-asserted at write #10 with K=4, N=4 -> ignored; 96 writes total, single done_o.
- Reset mid-transfer: rst_ni low after write #20 -> dst_we_o/busy_o drop immediately.
  - A new start after release with K=4, N=4, mem[i]=i gives dst[0..15] = 0..15 and done_o at t0+18.
- Minimum size: K=4, N=4 -> 16 writes, dst = identity, done_o at t0+18.
- With REMAP_INTRA_COL_MAJOR_EN, K=12, N=8, mem[i]=i -> dst[0..7] = 0,8,16,24,1,9,17,25; dst[16] = 4.
